lcd_write_ctrl: RTL

LCD_WRITE_CTRL -- requirements
Module: lcd_write_ctrl

---
 rtl/lcd_write_ctrl.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/lcd_write_ctrl.sv
// lcd_write_ctrl: HD44780 write-only byte sequencer with setup/enable/hold/exec timing
//
// Ports:
//   clk_clk      in   system clock, all state changes on rising edge
//   reset_reset  in   asynchronous active-high reset
//   cmd_valid    in   host presents a byte
//   cmd_rs       in   0 = instruction, 1 = character data
//   cmd_data     in   byte to write
//   cmd_ready    out  block can accept a byte (IDLE only)
//   busy         out  inverse of cmd_ready
//   lcd_data     out  DB7..DB0
//   lcd_rs       out  register select
//   lcd_rw       out  read/write, tied low
//   lcd_en       out  registered enable strobe
//
// Optional feature: define LCD_INIT_EN to add a PWRUP_CYC power-up delay followed by
// the init bytes 0x38, 0x0C, 0x01, 0x06 before the host is served.
module lcd_write_ctrl #(
    parameter int SETUP_CYC = 4,
    parameter int E_CYC     = 12,
    parameter int HOLD_CYC  = 4,
    parameter int EXEC_CYC  = 2000,
    parameter int LONG_CYC  = 82000,
    parameter int PWRUP_CYC = 750000
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic       cmd_valid,
    input  logic       cmd_rs,
    input  logic [7:0] cmd_data,
    output logic       cmd_ready,
    output logic       busy,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en
);
    function automatic int max2(int a, int b);
        return (a > b) ? a : b;
    endfunction

    // Counter is sized for the largest delay (PWRUP_CYC only affects width), never below 20 bits.
    localparam int MAX_CYC = max2(max2(max2(SETUP_CYC, E_CYC), max2(HOLD_CYC, EXEC_CYC)),
                                  max2(LONG_CYC, PWRUP_CYC));
    localparam int CW      = max2(20, $clog2(MAX_CYC + 1));

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_WAIT,
        S_PWRUP,
        S_INIT
    } state_t;

    state_t          r_state;
    state_t          w_state_nx;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nx;
    logic            r_rs;
    logic            w_rs_nx;
    logic [7:0]      r_data;
    logic [7:0]      w_data_nx;
    logic            r_en;
    logic            w_done;
    logic            w_long;

    assign w_done = (r_cnt == '0);
    // Clear display / return home need the long execution time.
    assign w_long = ~r_rs & ((r_data == 8'h01) | (r_data == 8'h02) | (r_data == 8'h03));

`ifdef LCD_INIT_EN
    logic [2:0]      r_idx;
    logic [2:0]      w_idx_nx;
    logic [7:0]      w_init_byte;
    logic            w_pwrup_done;

    assign w_init_byte  = r_idx[1] ? (r_idx[0] ? 8'h06 : 8'h01) : (r_idx[0] ? 8'h0C : 8'h38);
    // Reset clears the counter, so the power-up delay counts upward from zero.
    assign w_pwrup_done = (r_cnt == CW'(PWRUP_CYC - 1));
`endif

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = w_done ? r_cnt : r_cnt - 1'b1;
        w_rs_nx    = r_rs;
        w_data_nx  = r_data;
`ifdef LCD_INIT_EN
        w_idx_nx   = r_idx;
`endif
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_state_nx = S_SETUP;
                    w_cnt_nx   = CW'(SETUP_CYC - 1);
                    w_rs_nx    = cmd_rs;
                    w_data_nx  = cmd_data;
                end
            end
            S_SETUP: begin
                if (w_done) begin
                    w_state_nx = S_PULSE;
                    w_cnt_nx   = CW'(E_CYC - 1);
                end
            end
            S_PULSE: begin
                if (w_done) begin
                    w_state_nx = S_HOLD;
                    w_cnt_nx   = CW'(HOLD_CYC - 1);
                end
            end
            S_HOLD: begin
                if (w_done) begin
                    w_state_nx = S_WAIT;
                    w_cnt_nx   = w_long ? CW'(LONG_CYC - 1) : CW'(EXEC_CYC - 1);
                end
            end
            S_WAIT: begin
                if (w_done) begin
`ifdef LCD_INIT_EN
                    w_state_nx = (r_idx == 3'd4) ? S_IDLE : S_INIT;
`else
                    w_state_nx = S_IDLE;
`endif
                end
            end
`ifdef LCD_INIT_EN
            S_PWRUP: begin
                w_cnt_nx = w_pwrup_done ? '0 : r_cnt + 1'b1;
                if (w_pwrup_done) begin
                    w_state_nx = S_INIT;
                end
            end
            S_INIT: begin
                w_state_nx = S_SETUP;
                w_cnt_nx   = CW'(SETUP_CYC - 1);
                w_rs_nx    = 1'b0;
                w_data_nx  = w_init_byte;
                w_idx_nx   = r_idx + 1'b1;
            end
`endif
            default: begin
                w_state_nx = S_IDLE;
                w_cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
`ifdef LCD_INIT_EN
            r_state <= S_PWRUP;
`else
            r_state <= S_IDLE;
`endif
            r_cnt   <= '0;
            r_rs    <= 1'b0;
            r_data  <= 8'h00;
            r_en    <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_rs    <= w_rs_nx;
            r_data  <= w_data_nx;
            // Enable is a flop driven from the next state, so it cannot glitch.
            r_en    <= (w_state_nx == S_PULSE);
        end
    end

`ifdef LCD_INIT_EN
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_idx <= 3'd0;
        end else begin
            r_idx <= w_idx_nx;
        end
    end
`endif

    assign cmd_ready = (r_state == S_IDLE);
    assign busy      = ~cmd_ready;
    assign lcd_data  = r_data;
    assign lcd_rs    = r_rs;
    assign lcd_rw    = 1'b0;
    assign lcd_en    = r_en;

endmodule
